serial_alu: RTL and testbench
=============================

// Module: serial_alu
// PURPOSE
//  Bit-serial counterpart to the parallel 64-bit ALU: one single-bit datapath is reused over WIDTH cycles.
//  Operands are processed LSB-first with a registered carry. Result and NZCV flags are returned through a start/done handshake.
//  Sits beside the parallel ALU as the area-minimal execute unit for multi-cycle datapath experiments.
// PARAMETERS
//  WIDTH  64  operand/result width in bits, >=2
//  CW     $clog2(WIDTH)  bit-counter width, derived; not overridden
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      asynchronous, active-high; clears all state
//  start     in   1      request; sampled only when busy=0
//  A         in   WIDTH  operand A, captured on accepted start
//  B         in   WIDTH  operand B, captured on accepted start
//  cntrl     in   3      op: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
//  busy      out  1      high while bits are being processed
//  done      out  1      one-cycle pulse when result/flags are valid
//  result    out  WIDTH  final result, held until the next accepted start
//  negative  out  1      result[WIDTH-1]
//  zero      out  1      result == 0
//  overflow  out  1      signed overflow (add/sub only, else 0)
//  carry_out out  1      carry out of the MSB (add/sub only, else 0)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, result=0, all flags 0; bit count=0; carry=0. Mid-operation reset aborts and discards the operation.
//  FSM: IDLE -start-> RUN; RUN -(count==WIDTH-1)-> DONE; DONE -> IDLE, or DONE -start-> RUN.
//  Accept: start && state!=RUN. On accept, latch A, B and cntrl into shift registers; count=0; carry=(cntrl==011).
//  RUN: each cycle evaluates bit i=count from a[0], b[0] and carry. The result bit shifts in at the MSB of the result register.
//    a and b shift right by 1 and count increments. The carry register takes the slice carry (arith ops).
//  Subtract: adds ~b with carry-in 1 (two's complement).
//  At i=WIDTH-1, also capture cin_msb = the carry into the MSB.
//  Latency: start accepted at edge E0 -> bits at edges E1..E_WIDTH -> done=1 in the cycle after E_WIDTH (WIDTH cycles after accept).
//  DONE state: done=1 for exactly one cycle. Flags update together with done.
//    overflow = cin_msb ^ final carry.
//  busy=1 only in RUN. start while busy is ignored, with no effect on the operation in progress.
//  Between operations, result and flags hold their last values. They are not updated during RUN; the shift register is internal.
//  Back-to-back: start during DONE is accepted, so done and the new busy never overlap with stale data.
//  Unused cntrl codes (001, 111): result bits are 0, the operation still takes WIDTH cycles, and zero=1.
//  Logic operations: carry_out=0 and overflow=0. Pass B: result=B.
// STRUCTURE
//  Shared package alu_pkg: typedef enum logic[2:0] alu_op_t {ALU_PASSB=3'b000, ALU_ADD=3'b010,
//    ALU_SUB=3'b011, ALU_AND=3'b100, ALU_OR=3'b101, ALU_XOR=3'b110}; state typedef {S_IDLE,S_RUN,S_DONE}.
//  Sub-module serial_bit_slice (combinational): inputs a, b, cin, op; outputs out, cout.
//    It contains a full adder with a conditional B invert and and/or/xor, selected by op.
//  Top level: FSM, counter, operand/result shift registers, carry flop, flag logic.
// TESTING (WIDTH=64)
//  add: A=1, B=1 -> done 64 cycles after accept; result=2; N=0, Z=0, C=0, V=0.
//  sub: A=5, B=5 -> result=0, Z=1, C=1, V=0. Also sub A=0, B=1 -> result=64'hFFFF_FFFF_FFFF_FFFF, N=1, C=0.
//  add overflow: A=64'h7FFF_FFFF_FFFF_FFFF, B=1 -> result=64'h8000_0000_0000_0000, N=1, V=1, C=0.
//  xor/and/or/passB: A=64'hF0F0, B=64'hFF00 -> xor gives 64'h0FF0, and gives 64'hF000, or gives 64'hFFF0, passB gives 64'hFF00. C=V=0 in every case.
//  Mid-op start and reset: start pulsed at cycle 10 of RUN -> ignored, first result correct.
//    Then reset asserted at cycle 20 of a new op -> busy=0, done never pulses, all outputs 0 at once.
//  Back-to-back: start held high through DONE -> second op accepted with zero idle gap; done pulses twice, 65 cycles apart.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings, serial FSM states and a
// small helper that tells arithmetic operations apart from logic ones.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_PASSB = 3'b000,
        ALU_ADD   = 3'b010,
        ALU_SUB   = 3'b011,
        ALU_AND   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_XOR   = 3'b110
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Add and subtract are the only operations that produce a carry chain.
    function automatic logic is_arith(input logic [2:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/serial_bit_slice.sv
// One-bit ALU slice: full adder with conditional B inversion for subtract,
// plus and/or/xor and pass-B. Unused opcodes produce 0 with no carry.
module serial_bit_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       out,
    output logic       cout
);

    logic bx;
    logic sum;
    logic carry;

    // Operand conditioning, adder and per-opcode output select.
    always_comb begin
        bx    = (op == ALU_SUB) ? ~b : b;
        sum   = a ^ bx ^ cin;
        carry = (a & bx) | (a & cin) | (bx & cin);
        out   = 1'b0;
        cout  = 1'b0;
        case (op)
            ALU_PASSB: out = b;
            ALU_ADD,
            ALU_SUB: begin
                out  = sum;
                cout = carry;
            end
            ALU_AND:   out = a & b;
            ALU_OR:    out = a | b;
            ALU_XOR:   out = a ^ b;
            default: begin
                out  = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one slice reused over WIDTH cycles, operands consumed
// LSB-first with a registered carry. Result and NZCV flags are presented
// together with a one-cycle done pulse and held until the next accept.
module serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    count;
    logic             carry;
    logic [2:0]       op_q;

    logic             accept;
    logic             last_bit;
    logic             arith;
    logic             cin_msb;
    logic             slice_out;
    logic             slice_cout;
    logic [WIDTH-1:0] r_final;

    // Start is honoured in IDLE and DONE; ignored while bits are in flight.
    assign accept   = start && (state != S_RUN);
    assign last_bit = (state == S_RUN) && (count == CW'(WIDTH - 1));
    assign arith    = is_arith(op_q);
    // While the MSB is being evaluated the carry flop holds the carry into it.
    assign cin_msb  = carry;
    assign r_final  = {slice_out, r_sr[WIDTH-1:1]};

    serial_bit_slice u_slice (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .op   (op_q),
        .out  (slice_out),
        .cout (slice_cout)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (count == CW'(WIDTH - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand/result shift registers, bit counter and carry flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            count <= '0;
            carry <= 1'b0;
            op_q  <= 3'b000;
        end else if (accept) begin
            a_sr  <= A;
            b_sr  <= B;
            op_q  <= cntrl;
            count <= '0;
            // Subtract is A + ~B + 1, so the chain starts with carry set.
            carry <= (cntrl == ALU_SUB);
        end else if (state == S_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= r_final;
            count <= count + 1'b1;
            carry <= arith ? slice_cout : 1'b0;
        end
    end

    // Architectural result and flags, loaded only as the MSB completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else if (last_bit) begin
            result    <= r_final;
            negative  <= slice_out;
            zero      <= (r_final == '0);
            carry_out <= arith & slice_cout;
            overflow  <= arith & (cin_msb ^ slice_cout);
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed bench for serial_alu (WIDTH=64): arithmetic, logic, flag,
// latency, ignored mid-op start, mid-op reset and back-to-back cases.
module tb_serial_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;
    logic [3:0]  nzcv;

    int n_vec = 0;
    int n_err = 0;

    assign nzcv = {negative, zero, carry_out, overflow};

    serial_alu #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and wait for done; optionally pulse a stray start
    // at RUN cycle 'poke' (negative disables it).
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] op, input logic [63:0] exp_r,
                          input logic [3:0] exp_f, input int poke);
        int          lat;
        logic [63:0] prev_r;
        @(negedge clk);
        A      = a;
        B      = b;
        cntrl  = op;
        start  = 1'b1;
        prev_r = result;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (!done && lat < 100) begin
            if (lat == poke) begin
                start = 1'b1;
                A     = '1;
                B     = '1;
                cntrl = 3'b110;
            end else if (lat == poke + 1) begin
                start = 1'b0;
            end
            if (lat == 32) check({tag, "_hold"}, result, prev_r);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'd64);
        check({tag, "_res"}, result, exp_r);
        check({tag, "_nzcv"}, 64'(nzcv), 64'(exp_f));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int first;
        int second;
        int ndone;

        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        cntrl = 3'b000;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_res", result, 64'd0);
        check("rst_nzcv", 64'(nzcv), 64'd0);
        reset = 1'b0;

        run_op("add",   64'd1, 64'd1, 3'b010, 64'd2, 4'b0000, -1);
        run_op("sub0",  64'd5, 64'd5, 3'b011, 64'd0, 4'b0110, -1);
        run_op("subneg", 64'd0, 64'd1, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, -1);
        run_op("addovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010,
               64'h8000_0000_0000_0000, 4'b1001, -1);
        run_op("xor",   64'hF0F0, 64'hFF00, 3'b110, 64'h0FF0, 4'b0000, -1);
        run_op("and",   64'hF0F0, 64'hFF00, 3'b100, 64'hF000, 4'b0000, -1);
        run_op("or",    64'hF0F0, 64'hFF00, 3'b101, 64'hFFF0, 4'b0000, -1);
        run_op("passb", 64'hF0F0, 64'hFF00, 3'b000, 64'hFF00, 4'b0000, -1);
        run_op("op111", 64'hFFFF, 64'hFFFF, 3'b111, 64'd0, 4'b0100, -1);
        run_op("midst", 64'd3, 64'd4, 3'b010, 64'd7, 4'b0000, 10);

        // Reset twenty cycles into a new operation.
        @(negedge clk);
        A     = 64'd9;
        B     = 64'd9;
        cntrl = 3'b010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_res", result, 64'd0);
        check("mrst_nzcv", 64'(nzcv), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mrst_nodone", 64'(ndone), 64'd0);

        // Back-to-back with start held through DONE.
        @(negedge clk);
        A      = 64'd1;
        B      = 64'd1;
        cntrl  = 3'b010;
        start  = 1'b1;
        first  = -1;
        second = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (first >= 0 && second < 0 && c == first + 1)
                check("b2b_nogap", 64'(busy), 64'd1);
            if (done) begin
                if (first < 0) begin
                    first = c;
                    check("b2b_res1", result, 64'd2);
                    A = 64'd2;
                    B = 64'd3;
                end else if (second < 0) begin
                    second = c;
                    check("b2b_res2", result, 64'd5);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b_first", 64'(first), 64'd64);
        check("b2b_gap", 64'(second - first), 64'd65);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
